// File: rtl/muxnx1_rr.sv
// muxnx1_rr -- parametrised N-to-1 registered multiplexer with valid/ready
// output handshake and selectable arbitration (external selector or
// round-robin). Each consumed input is acknowledged with a one-hot pop.
//
// Parameters:
//   NUM_CH   number of input channels (power of two, 2..16)
//   DATA_W   data width per channel
//   SEL_W    selector / ch_out width, derived from NUM_CH (do not override)
//
// Ports:
//   clk        clock, all state on rising edge
//   reset_L    asynchronous active-low reset
//   mode       0 = external selector, 1 = round-robin
//   selector   channel index used when mode = 0
//   valid_in   per-channel valid
//   data_in    channel i at bits [i*DATA_W +: DATA_W]
//   out_ready  downstream accepts the output word this cycle
//   pop        combinational one-hot, channel captured at this edge
//   valid_out  registered output valid
//   data_out   registered output data
//   ch_out     registered index of the channel held in data_out
//
// Build option:
//   MUXNX1_ZERO_IDLE_EN  when defined, a load edge without a grant also
//                        clears data_out and ch_out; otherwise they hold.

module muxnx1_rr #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset_L,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         selector,
   input  logic [NUM_CH-1:0]        valid_in,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   input  logic                     out_ready,
   output logic [NUM_CH-1:0]        pop,
   output logic                     valid_out,
   output logic [DATA_W-1:0]        data_out,
   output logic [SEL_W-1:0]         ch_out
);

   logic [SEL_W-1:0]  rr_ptr;
   logic              load;
   logic              grant_vld;
   logic [SEL_W-1:0]  grant_idx;
   logic [SEL_W-1:0]  cand_idx;
   logic [DATA_W-1:0] ch_data [NUM_CH];

   // Output register may take a new word when empty or being drained.
   assign load = !valid_out || out_ready;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
         assign ch_data[gi] = data_in[gi*DATA_W +: DATA_W];
         // Reset gates pop so no source advances while the block is held.
         assign pop[gi] = reset_L & load & grant_vld & (grant_idx == SEL_W'(gi));
      end
   endgenerate

   // Grant selection. In round-robin mode the candidates are scanned from the
   // farthest (rr_ptr itself) to the nearest (rr_ptr+1); the last hit wins,
   // which makes the nearest valid channel after the pointer the grant.
   // NUM_CH is a power of two, so SEL_W-bit addition wraps modulo NUM_CH.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      if (!mode) begin
         grant_vld = valid_in[selector];
         grant_idx = selector;
      end else begin
         for (int k = NUM_CH; k >= 1; k--) begin
            cand_idx = rr_ptr + SEL_W'(k);
            if (valid_in[cand_idx]) begin
               grant_vld = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         ch_out    <= '0;
         // Parked on the last channel so the first search starts at 0.
         rr_ptr    <= SEL_W'(NUM_CH - 1);
      end else if (load) begin
         if (grant_vld) begin
            valid_out <= 1'b1;
            data_out  <= ch_data[grant_idx];
            ch_out    <= grant_idx;
            rr_ptr    <= grant_idx;
         end else begin
            valid_out <= 1'b0;
`ifdef MUXNX1_ZERO_IDLE_EN
            data_out  <= '0;
            ch_out    <= '0;
`else
            // data_out / ch_out keep their last values; valid_out qualifies.
`endif
         end
      end
   end

endmodule

// File: tb/tb_muxnx1_rr.sv
// tb_muxnx1_rr -- directed scoreboard bench for muxnx1_rr (NUM_CH=4, DATA_W=4).
// Stimulus pushes the expected word whenever it expects a pop; an independent
// monitor compares each word the DUT loads into its output register.

module tb_muxnx1_rr;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 4;
   localparam int SEL_W  = 2;

   logic                     clk = 1'b0;
   logic                     reset_L = 1'b1;
   logic                     mode;
   logic [SEL_W-1:0]         selector;
   logic [NUM_CH-1:0]        valid_in;
   logic [NUM_CH*DATA_W-1:0] data_in;
   logic                     out_ready;
   logic [NUM_CH-1:0]        pop;
   logic                     valid_out;
   logic [DATA_W-1:0]        data_out;
   logic [SEL_W-1:0]         ch_out;

   typedef struct {
      int ch;
      int data;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  chan_data [4];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   bit          pending = 1'b0;

   always #5 clk = ~clk;

   muxnx1_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .mode      (mode),
      .selector  (selector),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .out_ready (out_ready),
      .pop       (pop),
      .valid_out (valid_out),
      .data_out  (data_out),
      .ch_out    (ch_out)
   );

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Apply one cycle of inputs (at posedge+2), check pop, queue expected word.
   task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] exp_pop, input string name);
      mode      = m;
      selector  = s;
      valid_in  = v;
      out_ready = r;
      data_in   = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
      #1;
      chk({name, "_pop"}, int'(pop), int'(exp_pop));
      for (int i = 0; i < 4; i++)
         if (exp_pop[i]) exp_q.push_back('{ch: i, data: int'(chan_data[i])});
      @(posedge clk);
      #2;
   endtask

   // Monitor: a pop seen before an edge means a new word is on the output
   // after that edge; compare it at the following falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_L) begin
         pending = 1'b0;
      end else begin
         if (pending) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL mon_underflow: got word ch=%0d data=%0d expected none",
                        ch_out, data_out);
            end else begin
               e = exp_q.pop_front();
               $display("word ch=%0d data=%h", ch_out, data_out);
               chk("mon_valid", int'(valid_out), 1);
               chk("mon_data", int'(data_out), e.data);
               chk("mon_ch", int'(ch_out), e.ch);
            end
         end
         pending = (pop != '0);
      end
   end

   initial begin
      // Reset with every input at 1.
      mode = 1'b1; selector = 2'b11; valid_in = 4'hF; out_ready = 1'b1;
      data_in = '1;
      for (int i = 0; i < 4; i++) chan_data[i] = 4'hF;
      #1 reset_L = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_ch", int'(ch_out), 0);
      chk("rst_pop", int'(pop), 0);

      chan_data[0] = 4'hA; chan_data[1] = 4'hB;
      chan_data[2] = 4'hC; chan_data[3] = 4'hD;
      reset_L = 1'b1;
      drive(1, 0, 4'b1111, 1, 4'b0001, "first_rr");

      // Selector mode.
      drive(0, 0, 4'b1111, 1, 4'b0001, "sel0");
      drive(0, 1, 4'b1111, 1, 4'b0010, "sel1");
      drive(0, 2, 4'b1111, 1, 4'b0100, "sel2");
      drive(0, 3, 4'b1111, 1, 4'b1000, "sel3");
      drive(0, 2, 4'b1011, 1, 4'b0000, "bubble");
      chk("bubble_valid", int'(valid_out), 0);

      // Round-robin fairness, pointer at 3.
      for (int i = 0; i < 8; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (i % 4);
         drive(1, 0, 4'b1111, 1, oh, "rr_all");
      end
      for (int i = 0; i < 4; i++) begin
         logic [3:0] oh;
         oh = (i % 2 == 0) ? 4'b0010 : 4'b1000;
         drive(1, 0, 4'b1010, 1, oh, "rr_1010");
      end

      // Back-pressure on a ch2 word.
      drive(1, 0, 4'b0100, 1, 4'b0100, "bp_load");
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 4'b1111, 0, 4'b0000, "bp_stall");
         chk("bp_valid", int'(valid_out), 1);
         chk("bp_data", int'(data_out), 12);
         chk("bp_ch", int'(ch_out), 2);
      end
      drive(1, 0, 4'b1111, 1, 4'b1000, "bp_resume");

      // Asynchronous reset while a word is held.
      drive(1, 0, 4'b1111, 0, 4'b0000, "pre_rst");
      chk("pre_rst_valid", int'(valid_out), 1);
      reset_L = 1'b0;
      #1;
      chk("midrst_valid", int'(valid_out), 0);
      chk("midrst_data", int'(data_out), 0);
      chk("midrst_pop", int'(pop), 0);
      @(posedge clk); #2;
      reset_L = 1'b1;
      drive(1, 0, 4'b1111, 1, 4'b0001, "rst_rr");

      // Single valid channel is granted every cycle.
      drive(1, 0, 4'b0100, 1, 4'b0100, "single");
      drive(1, 0, 4'b0100, 1, 4'b0100, "single");

      // Idle behaviour after a word of 7 from ch1.
      chan_data[1] = 4'h7;
      drive(1, 0, 4'b0010, 1, 4'b0010, "m_load");
      drive(1, 0, 4'b0000, 1, 4'b0000, "m_idle");
      chk("m_valid", int'(valid_out), 0);
`ifdef MUXNX1_ZERO_IDLE_EN
      chk("m_data_zero", int'(data_out), 0);
      chk("m_ch_zero", int'(ch_out), 0);
`else
      chk("m_data_hold", int'(data_out), 7);
      chk("m_ch_hold", int'(ch_out), 1);
`endif

      drive(1, 0, 4'b0000, 1, 4'b0000, "drain");
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/muxnx1_rr.md
# muxnx1_rr

Parametrised N-to-1 registered multiplexer with valid/ready handshake and a selectable arbitration mode. It is the generalised successor of the fixed 4-channel, 4-bit muxes in the datapath. It merges NUM_CH valid-qualified lanes onto one output lane. Channels are chosen either by an external selector or by an internal round-robin arbiter, and each consumed input is acknowledged with a per-channel pop.

## Interface
Parameters:
- NUM_CH, 4: number of input channels; power of two, 2..16.
- DATA_W, 4: data width per channel.
- SEL_W, $clog2(NUM_CH): width of selector and ch_out; derived, not overridden.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- mode  in  1  0 = external selector, 1 = round-robin.
- selector  in  SEL_W  channel index used when mode=0.
- valid_in  in  NUM_CH  bit i qualifies channel i.
- data_in  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_ready  in  1  downstream accepts valid_out/data_out this cycle.
- pop  out  NUM_CH  combinational one-hot; bit i=1 means channel i is captured at this edge.
- valid_out  out  1  registered output valid.
- data_out  out  DATA_W  registered output data.
- ch_out  out  SEL_W  registered index of the channel held in data_out.

## Operation
- Load enable is `load = !valid_out || out_ready`. The output register accepts new data only when load=1.
- Grant selection is combinational. At most one grant is issued per cycle.
  - mode=0: grant channel `selector` if valid_in[selector]=1; otherwise no grant.
  - mode=1: search cyclically from rr_ptr+1 up to rr_ptr+NUM_CH, modulo NUM_CH, and grant the first i with valid_in[i]=1. If no channel is valid, there is no grant.
- pop = onehot(grant) & {NUM_CH{load}}. The source must drop or advance channel i after seeing pop[i].
- On an edge with load=1:
  - With a grant: valid_out<=1, data_out<=data_in[grant], ch_out<=grant.
  - Without a grant: valid_out<=0; data_out and ch_out follow the Configuration rule.
- On an edge with load=0 (valid_out=1, out_ready=0), all outputs hold and pop=0.
- rr_ptr updates to the granted index only on an edge where pop is nonzero, in either mode. The pointer is retained across mode changes.
- State is limited to the output register and rr_ptr. There is no FSM beyond these.

## Timing
- Latency is 1 cycle: data present with a grant at edge k appears on data_out after edge k.
- With out_ready held at 1, throughput is 1 transfer per cycle.
- Reset (asynchronous, reset_L=0) clears the following immediately and keeps them cleared while low:
  - valid_out=0, data_out=0, ch_out=0.
  - rr_ptr=NUM_CH-1, so the first round-robin search starts at channel 0.
  - pop is forced to 0 while reset_L=0.
- Reset asserted mid-transfer discards the held word. No pop is issued for it again.
- The first edge after reset_L rises behaves as load=1.
- If a single channel is valid in round-robin mode, it is granted every cycle; the pointer stays on it.
- If all channels are valid in round-robin mode, grants cycle 0,1,...,NUM_CH-1,0,... under continuous out_ready.
- Back-pressure: while valid_out=1 and out_ready=0, valid_in changes have no effect. Arbitration resumes on the cycle out_ready=1.
- In mode=0, an invalid selected channel produces a bubble even if other channels are valid.
- Changes to selector or mode take effect on the same cycle's grant. There is no registering of selector.

## Configuration
- MUXNX1_ZERO_IDLE_EN:
  - Defined: on any load edge without a grant, data_out<=0 and ch_out<=0.
  - Undefined: data_out and ch_out hold their last values when valid_out drops; only valid_out qualifies them.
  - Reset values are identical in both builds.

## Test plan
All scenarios use NUM_CH=4, DATA_W=4.
- Reset: hold reset_L=0 with every input at 1 → valid_out=0, data_out=0, ch_out=0, pop=0. Release, then mode=1 with valid_in=4'b1111 → first grant is ch 0 (pop=4'b0001).
- Selector mode: mode=0, data_in={4'hD,4'hC,4'hB,4'hA}, valid_in=4'b1111, selector stepping 0..3, out_ready=1 → data_out A,B,C,D one cycle after each select. With selector=2 and valid_in=4'b1011 → bubble, valid_out=0, pop=0.
- Round-robin fairness: mode=1, valid_in=4'b1111, out_ready=1 for 8 cycles → ch_out sequence 0,1,2,3,0,1,2,3. Then valid_in=4'b1010 → ch_out alternates 1,3.
- Back-pressure: a word from ch 2 is valid and out_ready=0 for 3 cycles → data_out and ch_out are stable and pop=0 throughout. When out_ready=1 → the next grant is ch 3, not ch 2.
- Reset mid-operation: assert reset_L=0 asynchronously between edges while valid_out=1 → valid_out falls immediately. After release, round-robin restarts at ch 0.
- Macro: drop valid_in to 0 after data_out=4'h7. With MUXNX1_ZERO_IDLE_EN defined → data_out=0 and ch_out=0 on the next edge. Without it → data_out stays 4'h7.
